fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Read-side consumer for the team's ring-buffer FIFO. It pulls words through the FIFO's one-cycle read handshake (`rd_en` out, `rd_data`/`rd_val` back) and transmits each word as an asynchronous serial (UART) frame on `tx`. It sits between a FIFO instance and an off-chip serial pin, and throttles reads to the line rate.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: word width; must match the FIFO `DATA_WIDTH`.
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit; must be ≥ 2.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity. Ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: number of stop bits; legal values are 1 or 2.

Ports (clock and reset first):
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  1 allows new FIFO reads; 0 lets the current frame finish, then holds idle.
- `fifo_rd_en`  out  1  one-cycle read request to the FIFO.
- `fifo_rd_data`  in  DATA_WIDTH  FIFO read data; valid in the cycle after `fifo_rd_en`.
- `fifo_rd_val`  in  1  1 in the cycle after `fifo_rd_en` means `fifo_rd_data` holds a word; 0 means the FIFO was empty.
- `tx`  out  1  serial line; idle level is high.
- `busy`  out  1  1 while a frame is on `tx` (states START, DATA, PARITY, STOP).
- `frame_done`  out  1  one-cycle pulse after the last stop bit completes.

## Operation
- FSM states: IDLE, WAIT, START, DATA, PARITY, STOP.
- IDLE:
  - If `enable`=1: assert `fifo_rd_en` for exactly this cycle, then go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If `fifo_rd_val`=1: latch `fifo_rd_data` into the shift register, compute the parity bit, go to START.
  - If `fifo_rd_val`=0: go to IDLE. While the FIFO is empty, `fifo_rd_en` therefore pulses every second cycle.
- START: drive `tx`=0 for `CLKS_PER_BIT` cycles.
- DATA: send `DATA_WIDTH` bits, LSB first, each held for `CLKS_PER_BIT` cycles.
- PARITY (only when `PARITY_EN`=1): send one bit for `CLKS_PER_BIT` cycles.
  - Even parity: bit = XOR of all data bits.
  - Odd parity: bit = inverted XOR of all data bits.
- STOP: drive `tx`=1 for `STOP_BITS`×`CLKS_PER_BIT` cycles, then go to IDLE and pulse `frame_done`.
- Counter widths:
  - Baud counter: $clog2(`CLKS_PER_BIT`) bits; counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on each bit boundary.
  - Bit index: $clog2(`DATA_WIDTH`+1) bits.
- `fifo_rd_en` is never asserted outside IDLE, so at most one read is outstanding.
- `fifo_rd_val` and `fifo_rd_data` are ignored in every state except WAIT.
- `enable` is sampled only in IDLE. Deasserting it mid-frame does not shorten the frame.

## Timing
- Reset values: `tx`=1, `fifo_rd_en`=0, `busy`=0, `frame_done`=0, FSM=IDLE, counters=0.
- Reset asserted mid-frame:
  - On the next clock edge, `tx`=1 and all outputs return to their reset values.
  - The latched word is discarded; no partial frame resumes.
- All outputs are registered.
- Read-to-line latency:
  - `fifo_rd_en` high in cycle N; the word is captured in cycle N+1.
  - `tx`=0 and `busy`=1 from cycle N+2.
- Frame length: (1 + `DATA_WIDTH` + `PARITY_EN` + `STOP_BITS`) × `CLKS_PER_BIT` cycles, with `busy`=1 throughout.
- `frame_done`:
  - Asserted in the first IDLE cycle after the stop bits.
  - In that same cycle, `fifo_rd_en` asserts if `enable`=1.
- Back-to-back frames: exactly 2 extra cycles of `tx`=1 (the IDLE and WAIT cycles) between the end of the stop bits and the next start bit.
- Reset has priority over every other input in the same cycle.

## Test plan
- Single word, `CLKS_PER_BIT`=4, `DATA_WIDTH`=8, no parity, 1 stop bit; FIFO holds 0xA5.
  - `tx` bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles total).
  - `busy` is high for those 40 cycles.
  - One `frame_done` pulse follows.
- Empty FIFO, `enable`=1, for 10 cycles after reset.
  - `fifo_rd_en` = 1,0,1,0,…
  - `tx` stays 1, `busy` stays 0.
- Parity checks:
  - Even parity, word 0x07: parity bit = 1.
  - Odd parity, word 0x00: parity bit = 1.
  - `STOP_BITS`=2: stop level lasts 8 cycles.
- Back-to-back words 0x00 then 0xFF.
  - Exactly 2 idle-high cycles appear between frames.
  - Exactly two `frame_done` pulses.
  - The FIFO receives exactly 3 `rd_en` pulses: 2 that return data and a third that returns `rd_val`=0 if the FIFO is then empty.
- Reset during DATA bit 3 of 0x5A: `tx`=1 on the next cycle, `busy`=0, and no further toggling after reset is released while the FIFO is empty.
- Deassert `enable` during frame 1 while 3 words are queued: frame 1 completes, and no `fifo_rd_en` follows until `enable` returns to 1.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// Drains words from a ring-buffer FIFO through its one-cycle read handshake and
// sends each one as a UART frame on tx: start bit, data LSB first, optional parity, stop bits.
module fifo_uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_rd_val,
   output logic                  tx,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = $clog2(DATA_WIDTH + 1);

   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] DATA_LAST = IW'(DATA_WIDTH - 1);
   localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
   localparam logic          ODD_SEL   = (PARITY_ODD != 0);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WAIT   = 3'd1;
   localparam logic [2:0] S_START  = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_PARITY = 3'd4;
   localparam logic [2:0] S_STOP   = 3'd5;

   logic [2:0]            state_reg;
   logic [BW-1:0]         baud_reg;
   logic [IW-1:0]         bit_reg;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic                  parity_reg;
   logic                  rd_en_reg;
   logic                  tx_reg;
   logic                  busy_reg;
   logic                  done_reg;
   logic                  bit_end;

   assign bit_end    = (baud_reg == BAUD_LAST);
   assign fifo_rd_en = rd_en_reg;
   assign tx         = tx_reg;
   assign busy       = busy_reg;
   assign frame_done = done_reg;

   // tx is updated on the edge that starts each bit so the line is glitch-free and registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= S_IDLE;
         baud_reg   <= '0;
         bit_reg    <= '0;
         shift_reg  <= '0;
         parity_reg <= 1'b0;
         rd_en_reg  <= 1'b0;
         tx_reg     <= 1'b1;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         done_reg  <= 1'b0;
         rd_en_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               // A pending read request leaves IDLE; otherwise request on enable.
               if (rd_en_reg) begin
                  state_reg <= S_WAIT;
               end else begin
                  rd_en_reg <= enable;
               end
            end
            S_WAIT: begin
               if (fifo_rd_val) begin
                  shift_reg  <= fifo_rd_data;
                  parity_reg <= (^fifo_rd_data) ^ ODD_SEL;
                  tx_reg     <= 1'b0;
                  busy_reg   <= 1'b1;
                  baud_reg   <= '0;
                  state_reg  <= S_START;
               end else begin
                  rd_en_reg <= enable;
                  state_reg <= S_IDLE;
               end
            end
            S_START: begin
               baud_reg <= baud_reg + BW'(1);
               if (bit_end) begin
                  baud_reg  <= '0;
                  tx_reg    <= shift_reg[0];
                  shift_reg <= shift_reg >> 1;
                  bit_reg   <= '0;
                  state_reg <= S_DATA;
               end
            end
            S_DATA: begin
               baud_reg <= baud_reg + BW'(1);
               if (bit_end) begin
                  baud_reg <= '0;
                  if (bit_reg == DATA_LAST) begin
                     bit_reg <= '0;
                     if (PARITY_EN != 0) begin
                        tx_reg    <= parity_reg;
                        state_reg <= S_PARITY;
                     end else begin
                        tx_reg    <= 1'b1;
                        state_reg <= S_STOP;
                     end
                  end else begin
                     tx_reg    <= shift_reg[0];
                     shift_reg <= shift_reg >> 1;
                     bit_reg   <= bit_reg + IW'(1);
                  end
               end
            end
            S_PARITY: begin
               baud_reg <= baud_reg + BW'(1);
               if (bit_end) begin
                  baud_reg  <= '0;
                  bit_reg   <= '0;
                  tx_reg    <= 1'b1;
                  state_reg <= S_STOP;
               end
            end
            S_STOP: begin
               baud_reg <= baud_reg + BW'(1);
               if (bit_end) begin
                  baud_reg <= '0;
                  if (bit_reg == STOP_LAST) begin
                     bit_reg   <= '0;
                     busy_reg  <= 1'b0;
                     done_reg  <= 1'b1;
                     rd_en_reg <= enable;
                     state_reg <= S_IDLE;
                  end else begin
                     bit_reg <= bit_reg + IW'(1);
                  end
               end
            end
            default: begin
               state_reg <= S_IDLE;
               tx_reg    <= 1'b1;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: three parameter variants, each fed by a queue-based
// FIFO model, with a cycle-exact expected line stream built from the frame format.
module tb_fifo_uart_tx;

   logic       clk;
   logic       reset;
   logic [2:0] enable;
   logic [2:0] fifo_rd_en;
   logic [2:0] fifo_rd_val;
   logic [2:0] tx;
   logic [2:0] busy;
   logic [2:0] frame_done;
   logic [7:0] fifo_rd_data [3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_plain (
      .clk(clk), .reset(reset), .enable(enable[0]), .fifo_rd_en(fifo_rd_en[0]),
      .fifo_rd_data(fifo_rd_data[0]), .fifo_rd_val(fifo_rd_val[0]), .tx(tx[0]),
      .busy(busy[0]), .frame_done(frame_done[0]));

   fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_even (
      .clk(clk), .reset(reset), .enable(enable[1]), .fifo_rd_en(fifo_rd_en[1]),
      .fifo_rd_data(fifo_rd_data[1]), .fifo_rd_val(fifo_rd_val[1]), .tx(tx[1]),
      .busy(busy[1]), .frame_done(frame_done[1]));

   fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(3), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
      .clk(clk), .reset(reset), .enable(enable[2]), .fifo_rd_en(fifo_rd_en[2]),
      .fifo_rd_data(fifo_rd_data[2]), .fifo_rd_val(fifo_rd_val[2]), .tx(tx[2]),
      .busy(busy[2]), .frame_done(frame_done[2]));

   int         checks = 0;
   int         errors = 0;
   int         cyc    = 0;
   logic [7:0] fifo_q [3][$];
   logic [2:0] exp_q  [3][$];
   logic       tx_log [3][$];
   int         rd_cnt   [3];
   int         done_cnt [3];
   int         gap_run  [3];
   int         last_gap [3];

   typedef struct {
      int         inst;
      logic [7:0] word;
      string      pattern;
   } vec_t;
   vec_t vecs [6];

   function automatic int cpb(input int i);
      return (i == 2) ? 3 : 4;
   endfunction
   function automatic bit par_en(input int i);
      return i != 0;
   endfunction
   function automatic bit par_odd(input int i);
      return i == 2;
   endfunction
   function automatic int stops(input int i);
      return (i == 1) ? 2 : 1;
   endfunction

   task automatic check(input string name, input int inst, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d cycle %0d: got %0d expected %0d", name, inst, cyc, act, exp);
      end
   endtask

   // Expected line after a word is accepted: frame bits then one idle cycle carrying frame_done.
   task automatic push_frame(input int i, input logic [7:0] d);
      logic bits [$];
      bits.push_back(1'b0);
      for (int b = 0; b < 8; b++) bits.push_back(d[b]);
      if (par_en(i)) bits.push_back((^d) ^ par_odd(i));
      for (int s = 0; s < stops(i); s++) bits.push_back(1'b1);
      foreach (bits[k])
         for (int c = 0; c < cpb(i); c++) exp_q[i].push_back({bits[k], 1'b1, 1'b0});
      exp_q[i].push_back(3'b101);
   endtask

   task automatic step();
      logic       rst_s;
      logic [2:0] rd_s;
      logic [2:0] en_s;
      logic [2:0] e;
      rst_s = reset;
      rd_s  = fifo_rd_en;
      en_s  = enable;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 3; i++) begin
         if (rst_s) exp_q[i].delete();
         e = 3'b100;
         if (exp_q[i].size() > 0) e = exp_q[i].pop_front();
         check("tx", i, tx[i], e[2]);
         check("busy", i, busy[i], e[1]);
         check("frame_done", i, frame_done[i], e[0]);
         check("rd_en_during_frame", i, fifo_rd_en[i] & e[1], 0);
         check("rd_en_single_cycle", i, fifo_rd_en[i] & rd_s[i], 0);
         check("rd_en_without_enable", i, fifo_rd_en[i] & ~en_s[i], 0);
         rd_cnt[i]   += int'(fifo_rd_en[i]);
         done_cnt[i] += int'(frame_done[i]);
         if (busy[i]) begin
            tx_log[i].push_back(tx[i]);
            if (gap_run[i] > 0) last_gap[i] = gap_run[i];
            gap_run[i] = 0;
         end else begin
            gap_run[i]++;
         end
         fifo_rd_data[i] = 8'($urandom);
         fifo_rd_val[i]  = 1'b0;
         if (!rst_s && rd_s[i] && fifo_q[i].size() > 0) begin
            fifo_rd_val[i]  = 1'b1;
            fifo_rd_data[i] = fifo_q[i].pop_front();
            push_frame(i, fifo_rd_data[i]);
         end
      end
   endtask

   task automatic wait_done(input int i, input int n, input int limit);
      int target;
      int k;
      target = done_cnt[i] + n;
      k = 0;
      while (done_cnt[i] < target && k < limit) begin
         step();
         k++;
      end
      check("frame_done_timeout", i, int'(done_cnt[i] >= target), 1);
   endtask

   task automatic wait_busy(input int i, input int limit);
      int k;
      k = 0;
      while (!busy[i] && k < limit) begin
         step();
         k++;
      end
      check("busy_timeout", i, busy[i], 1);
   endtask

   initial begin
      int r0;
      int d0;
      int lows;
      int idx;
      int k;

      vecs[0] = '{0, 8'hA5, "0101001011"};
      vecs[1] = '{1, 8'h07, "011100000111"};
      vecs[2] = '{2, 8'h00, "00000000011"};
      vecs[3] = '{0, 8'hFF, "0111111111"};
      vecs[4] = '{1, 8'h00, "000000000011"};
      vecs[5] = '{2, 8'h81, "01000000111"};

      reset       = 1'b1;
      enable      = 3'b000;
      fifo_rd_val = 3'b000;
      for (int i = 0; i < 3; i++) begin
         fifo_rd_data[i] = 8'h00;
         rd_cnt[i]   = 0;
         done_cnt[i] = 0;
         gap_run[i]  = 0;
         last_gap[i] = 0;
      end

      // Reset state, with enable already high so reset priority is exercised.
      step();
      enable = 3'b001;
      step();
      for (int i = 0; i < 3; i++) begin
         check("reset_tx", i, tx[i], 1);
         check("reset_busy", i, busy[i], 0);
         check("reset_rd_en", i, fifo_rd_en[i], 0);
         check("reset_frame_done", i, frame_done[i], 0);
      end

      // Empty FIFO: read requests alternate 1,0,1,0 from the first cycle after reset.
      reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         check("empty_rd_en_pattern", 0, fifo_rd_en[0], int'(c % 2 == 0));
         check("empty_tx_idle", 0, tx[0], 1);
      end
      enable = 3'b000;
      repeat (4) step();

      // Table-driven single-frame vectors.
      for (int v = 0; v < 6; v++) begin
         int i;
         i = vecs[v].inst;
         tx_log[i].delete();
         d0 = done_cnt[i];
         fifo_q[i].push_back(vecs[v].word);
         enable[i] = 1'b1;
         wait_done(i, 1, 300);
         enable[i] = 1'b0;
         repeat (4) step();
         check("frame_len", i, tx_log[i].size(), vecs[v].pattern.len() * cpb(i));
         check("frame_done_count", i, done_cnt[i] - d0, 1);
         for (int b = 0; b < vecs[v].pattern.len(); b++) begin
            idx = b * cpb(i) + cpb(i) / 2;
            if (idx < tx_log[i].size())
               check("frame_bit", i, tx_log[i][idx], int'(vecs[v].pattern.getc(b) == 8'h31));
            else
               check("frame_bit_missing", i, idx, tx_log[i].size() - 1);
         end
      end

      // Back-to-back 0x00 then 0xFF: two idle cycles between frames, three read requests.
      r0 = rd_cnt[0];
      d0 = done_cnt[0];
      fifo_q[0].push_back(8'h00);
      fifo_q[0].push_back(8'hFF);
      enable[0] = 1'b1;
      wait_done(0, 2, 300);
      enable[0] = 1'b0;
      check("b2b_gap", 0, last_gap[0], 2);
      repeat (10) step();
      check("b2b_rd_en_count", 0, rd_cnt[0] - r0, 3);
      check("b2b_done_count", 0, done_cnt[0] - d0, 2);

      // Reset during data bit 3 of 0x5A.
      fifo_q[0].push_back(8'h5A);
      enable[0] = 1'b1;
      wait_busy(0, 20);
      enable[0] = 1'b0;
      repeat (17) step();
      reset = 1'b1;
      step();
      check("midreset_tx", 0, tx[0], 1);
      check("midreset_busy", 0, busy[0], 0);
      reset = 1'b0;
      lows = 0;
      for (int c = 0; c < 30; c++) begin
         step();
         lows += int'(tx[0] == 1'b0);
      end
      check("midreset_no_toggle", 0, lows, 0);

      // Enable dropped during frame 1 with three words queued.
      for (int w = 0; w < 3; w++) fifo_q[1].push_back(8'($urandom));
      r0 = rd_cnt[1];
      enable[1] = 1'b1;
      wait_busy(1, 20);
      enable[1] = 1'b0;
      wait_done(1, 1, 300);
      repeat (60) step();
      check("hold_rd_en_count", 1, rd_cnt[1] - r0, 1);
      check("hold_words_left", 1, fifo_q[1].size(), 2);
      enable[1] = 1'b1;
      wait_done(1, 2, 400);
      enable[1] = 1'b0;
      repeat (5) step();
      check("hold_resume_drained", 1, fifo_q[1].size(), 0);

      // Randomized traffic on all three variants.
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < 3; i++) begin
            if ($urandom_range(7) == 0 && fifo_q[i].size() < 4) fifo_q[i].push_back(8'($urandom));
            enable[i] = ($urandom_range(3) != 0);
         end
         step();
      end
      enable = 3'b111;
      k = 0;
      while (k < 4000 && (fifo_q[0].size() + fifo_q[1].size() + fifo_q[2].size()) != 0) begin
         step();
         k++;
      end
      enable = 3'b000;
      repeat (80) step();
      check("random_fifo_drained", -1, fifo_q[0].size() + fifo_q[1].size() + fifo_q[2].size(), 0);
      check("random_frames_complete", -1, exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
